// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM state encoding and helpers shared by the multicycle ALU
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  function automatic int shamt_w(input int width);
    return $clog2(width);
  endfunction
  function automatic logic is_shift_op(input logic [3:0] o);
    return o == OP_SLL || o == OP_SRL || o == OP_SRA;
  endfunction
endpackage

// File: rtl/alu_shift_step.sv
// alu_shift_step: combinational shifter moving an operand by at most STEP bits
module alu_shift_step #(
  parameter int WIDTH = 32,
  parameter int STEP = 1,
  parameter int AW = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] operand,
  input  logic [AW-1:0]    amount,
  input  logic             dir,
  input  logic             arith,
  output logic [WIDTH-1:0] shifted
);
  logic [WIDTH:0] ext;
  // extend by one bit carrying the fill value so one signed shift covers SRL and SRA
  always_comb begin
    ext = {arith & operand[WIDTH-1], operand};
    shifted = dir ? WIDTH'($signed(ext) >>> amount) : operand << amount;
  end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: RV32I integer ALU with valid/ready handshakes and iterative shifter
module alu_multicycle import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] res,
  output logic             err
);
  localparam int SW = shamt_w(WIDTH);
  localparam int AW = $clog2(SHIFT_STEP) + 1;
  logic [1:0]       state;
  logic [WIDTH-1:0] sh, shifted, alu_res;
  logic [SW-1:0]    rem, shamt;
  logic [AW-1:0]    amt;
  logic [WIDTH:0]   sum;
  logic             dir, arith, sub, legal, last, lt_s, lt_u;
  assign req_ready = state == S_IDLE;
  assign resp_valid = state == S_DONE;
  // single adder serves ADD/SUB/SLT/SLTU; logic ops and result select are direct
  always_comb begin
    shamt = b[SW-1:0];
    sub = op == OP_SUB || op == OP_SLT || op == OP_SLTU;
    legal = is_shift_op(op) || sub || op == OP_ADD || op == OP_XOR || op == OP_OR || op == OP_AND;
    sum = {1'b0, a} + {1'b0, sub ? ~b : b} + (WIDTH+1)'(sub);
    lt_s = (a[WIDTH-1] ^ b[WIDTH-1]) ? a[WIDTH-1] : sum[WIDTH-1];
    lt_u = !sum[WIDTH];
    alu_res = (op == OP_ADD || op == OP_SUB) ? sum[WIDTH-1:0] :
              op == OP_SLT  ? WIDTH'(lt_s) :
              op == OP_SLTU ? WIDTH'(lt_u) :
              op == OP_XOR  ? a ^ b :
              op == OP_OR   ? a | b :
              op == OP_AND  ? a & b : a;
    last = {1'b0, rem} <= (SW+1)'(SHIFT_STEP);
    amt = last ? AW'(rem) : AW'(SHIFT_STEP);
  end
  alu_shift_step #(.WIDTH(WIDTH), .STEP(SHIFT_STEP), .AW(AW)) u_step (
    .operand(sh),
    .amount(amt),
    .dir(dir),
    .arith(arith),
    .shifted(shifted)
  );
  // request capture, shift iteration and response handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sh <= '0;
      rem <= '0;
      dir <= 1'b0;
      arith <= 1'b0;
      res <= '0;
      err <= 1'b0;
    end else if (state == S_IDLE && req_valid) begin
      sh <= a;
      rem <= shamt;
      dir <= op[2];
      arith <= op[3];
      if (legal && is_shift_op(op) && shamt != '0) begin
        state <= S_SHIFT;
      end else begin
        state <= S_DONE;
        res <= legal ? alu_res : '0;
        err <= !legal;
      end
    end else if (state == S_SHIFT) begin
      sh <= shifted;
      rem <= last ? '0 : rem - SW'(SHIFT_STEP);
      if (last) begin
        state <= S_DONE;
        res <= shifted;
        err <= 1'b0;
      end
    end else if (state == S_DONE && resp_ready) begin
      state <= S_IDLE;
    end
  end
endmodule
